t03_vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; next generation of the team's combinational sync comparator.

---
 rtl/t03_vga_timing_gen_pkg.sv | 33 +++
 rtl/t03_vga_timing_gen_if.sv | 41 ++++
 rtl/t03_vga_timing_gen_axis_counter.sv | 57 +++++
 rtl/t03_vga_timing_gen.sv | 104 ++++++++++
 tb/tb_t03_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/t03_vga_timing_gen_pkg.sv
// Shared region type, default 800x600@60 timing and count helpers for the
// VGA raster timing generator.
package t03_vga_pkg;

  typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} vga_region_t;

  localparam int DEF_CW       = 11;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 1;

  function automatic int vga_total(input int sync_w, input int back_w,
                                   input int active_w, input int front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

  // A zero-width back porch simply never matches, so that region is skipped.
  function automatic vga_region_t vga_region_of(input int cnt, input int sync_w,
                                                input int back_w, input int active_w);
    vga_region_t r;
    if (cnt < sync_w)                          r = SYNC;
    else if (cnt < sync_w + back_w)            r = BACK;
    else if (cnt < sync_w + back_w + active_w) r = ACTIVE;
    else                                       r = FRONT;
    return r;
  endfunction

endpackage

// File: rtl/t03_vga_timing_gen_if.sv
// Pixel-strobe inputs and raster outputs of t03_vga_timing_gen.
// T03_VGA_FRAME_CNT_EN adds the frame_cnt and vblank signals.
interface t03_vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          pix_en;
  logic          restart;
  logic          hsync;
  logic          vsync;
  logic          at_display;
  logic [CW-1:0] px_x;
  logic [CW-1:0] px_y;
  logic          line_start;
  logic          frame_start;

`ifdef T03_VGA_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
  logic          vblank;

  modport master (
    output pix_en, restart,
    input  hsync, vsync, at_display, px_x, px_y, line_start, frame_start,
           frame_cnt, vblank
  );
  modport slave (
    input  pix_en, restart,
    output hsync, vsync, at_display, px_x, px_y, line_start, frame_start,
           frame_cnt, vblank
  );
`else
  modport master (
    output pix_en, restart,
    input  hsync, vsync, at_display, px_x, px_y, line_start, frame_start
  );
  modport slave (
    input  pix_en, restart,
    output hsync, vsync, at_display, px_x, px_y, line_start, frame_start
  );
`endif

endinterface

// File: rtl/t03_vga_timing_gen_axis_counter.sv
// One raster axis: position counter plus SYNC/BACK/ACTIVE/FRONT region FSM,
// exposing the next-state decode so the parent can register zero-latency outputs.
//   state  | meaning
//   SYNC   | cnt in [0, SYNC_W-1], sync pulse asserted
//   BACK   | back porch, skipped when BACK_W = 0
//   ACTIVE | visible pixels / lines
//   FRONT  | front porch, skipped when FRONT_W = 0
module t03_vga_axis_counter
  import t03_vga_pkg::*;
#(
  parameter int CW       = 11,
  parameter int SYNC_W   = 128,
  parameter int BACK_W   = 88,
  parameter int ACTIVE_W = 800,
  parameter int FRONT_W  = 40
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          inc,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output vga_region_t   region,
  output logic          wrap,
  output logic [CW-1:0] cnt_next,
  output vga_region_t   region_next
);

  localparam int            TOTAL = vga_total(SYNC_W, BACK_W, ACTIVE_W, FRONT_W);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

  if (TOTAL > (2 ** CW)) begin : g_total_chk
    $error("t03_vga_axis_counter: total count %0d does not fit in %0d bits", TOTAL, CW);
  end
  if (SYNC_W < 1 || ACTIVE_W < 1 || BACK_W < 0 || FRONT_W < 0) begin : g_width_chk
    $error("t03_vga_axis_counter: SYNC and ACTIVE need >= 1, porches >= 0");
  end

  // Clear wins over a coincident wrap, so wrap never fires on a clear edge.
  always_comb begin
    wrap = inc && !clear && (cnt == LAST);
    if (clear || wrap) cnt_next = '0;
    else if (inc)      cnt_next = cnt + 1'b1;
    else               cnt_next = cnt;
    region_next = vga_region_of(int'(cnt_next), SYNC_W, BACK_W, ACTIVE_W);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt    <= '0;
      region <= SYNC;
    end else begin
      cnt    <= cnt_next;
      region <= region_next;
    end
  end

endmodule

// File: rtl/t03_vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered sync, display-enable,
// coordinates and line/frame pulses. T03_VGA_FRAME_CNT_EN adds frame_cnt/vblank.
module t03_vga_timing_gen
  import t03_vga_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int HS_NEG   = 1,
  parameter int VS_NEG   = 1
) (
  input logic                  clk,
  input logic                  nRst,
  t03_vga_timing_gen_if.slave  vga
);

  localparam logic [CW-1:0] H_OFF  = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] V_OFF  = CW'(V_SYNC + V_BACK);
  localparam logic          HS_ACT = (HS_NEG == 0);
  localparam logic          VS_ACT = (VS_NEG == 0);

  logic [CW-1:0] h_cnt, h_cnt_next, v_cnt, v_cnt_next;
  vga_region_t   h_region, h_region_next, v_region, v_region_next;
  logic          h_wrap, v_wrap;
  logic          v_inc;
  logic          disp_next;
  logic          fs_next;
  logic          unused_state;

  assign v_inc = vga.pix_en & h_wrap;

  t03_vga_axis_counter #(
    .CW(CW), .SYNC_W(H_SYNC), .BACK_W(H_BACK), .ACTIVE_W(H_ACTIVE), .FRONT_W(H_FRONT)
  ) u_h_axis (
    .clk         (clk),
    .nRst        (nRst),
    .inc         (vga.pix_en),
    .clear       (vga.restart),
    .cnt         (h_cnt),
    .region      (h_region),
    .wrap        (h_wrap),
    .cnt_next    (h_cnt_next),
    .region_next (h_region_next)
  );

  t03_vga_axis_counter #(
    .CW(CW), .SYNC_W(V_SYNC), .BACK_W(V_BACK), .ACTIVE_W(V_ACTIVE), .FRONT_W(V_FRONT)
  ) u_v_axis (
    .clk         (clk),
    .nRst        (nRst),
    .inc         (v_inc),
    .clear       (vga.restart),
    .cnt         (v_cnt),
    .region      (v_region),
    .wrap        (v_wrap),
    .cnt_next    (v_cnt_next),
    .region_next (v_region_next)
  );

  // Outputs are driven from the next-state decode; the registered copies stay internal.
  assign unused_state = ^{h_cnt, v_cnt, h_region, v_region};

  assign disp_next = (h_region_next == ACTIVE) && (v_region_next == ACTIVE);
  assign fs_next   = vga.restart | (h_wrap & v_wrap);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      vga.hsync       <= HS_ACT;
      vga.vsync       <= VS_ACT;
      vga.at_display  <= 1'b0;
      vga.px_x        <= '0;
      vga.px_y        <= '0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hsync       <= (h_region_next == SYNC) ? HS_ACT : ~HS_ACT;
      vga.vsync       <= (v_region_next == SYNC) ? VS_ACT : ~VS_ACT;
      vga.at_display  <= disp_next;
      vga.px_x        <= disp_next ? (h_cnt_next - H_OFF) : '0;
      vga.px_y        <= disp_next ? (v_cnt_next - V_OFF) : '0;
      vga.line_start  <= vga.restart | h_wrap;
      vga.frame_start <= fs_next;
    end
  end

`ifdef T03_VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      vga.frame_cnt <= '0;
      vga.vblank    <= 1'b1;
    end else begin
      if (fs_next) vga.frame_cnt <= vga.frame_cnt + 16'd1;
      vga.vblank <= (v_region_next != ACTIVE);
    end
  end
`endif

endmodule

// File: tb/tb_t03_vga_timing_gen.sv
// Directed bench for t03_vga_timing_gen on a tiny 8x6 raster (H 2/1/4/1, V 1/1/3/1).
// Builds with or without T03_VGA_FRAME_CNT_EN.
module tb_t03_vga_timing_gen;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic nRst;

  always #5 clk = ~clk;

  t03_vga_timing_gen_if #(.CW(CW)) vga_bus ();

  t03_vga_timing_gen #(
    .CW(CW),
    .H_SYNC(2), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .HS_NEG(1), .VS_NEG(1)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .vga  (vga_bus)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] x;
    logic [3:0] y;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    logic pe;
    logic rs;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;  // enabled edges since the last restart/reset

  function automatic vec_t mk(input logic pe, input logic rs, input logic hs, input logic vs,
                              input logic de, input int x, input int y,
                              input logic ls, input logic fs);
    vec_t v;
    v.pe = pe;  v.rs = rs;
    v.exp.hs = hs;  v.exp.vs = vs;  v.exp.de = de;
    v.exp.x = 4'(x);  v.exp.y = 4'(y);
    v.exp.ls = ls;  v.exp.fs = fs;
    return v;
  endfunction

  function automatic out_t cur_out();
    out_t o;
    o.hs = vga_bus.hsync;       o.vs = vga_bus.vsync;
    o.de = vga_bus.at_display;  o.x  = vga_bus.px_x;
    o.y  = vga_bus.px_y;        o.ls = vga_bus.line_start;
    o.fs = vga_bus.frame_start;
    return o;
  endfunction

  // Expected outputs after `pos` enabled edges; pe_edge says whether the last edge advanced.
  function automatic out_t model_out(input int pos, input logic pe_edge);
    out_t o;
    int h;
    int v;
    h = pos % 8;
    v = (pos / 8) % 6;
    o.hs = (h >= 2);
    o.vs = (v >= 1);
    o.de = (h >= 3) && (h <= 6) && (v >= 2) && (v <= 4);
    o.x  = o.de ? 4'(h - 3) : 4'd0;
    o.y  = o.de ? 4'(v - 2) : 4'd0;
    o.ls = pe_edge && (h == 0);
    o.fs = pe_edge && (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = cur_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got hs/vs/de/x/y/ls/fs=%b/%b/%b/%0d/%0d/%b/%b expected %b/%b/%b/%0d/%0d/%b/%b",
               name, act.hs, act.vs, act.de, act.x, act.y, act.ls, act.fs,
               exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic pe, input logic rs);
    vga_bus.pix_en  = pe;
    vga_bus.restart = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    step(1'b0, 1'b1);
    n = 0;
    check_out("restart_entry", model_out(0, 1'b1));
  endtask

  task automatic run_model(input int ncyc, input bit toggle, input string name,
                           output int fs_cnt, output int ls_cnt,
                           output int fs_first, output int fs_last);
    logic pe;
    fs_cnt = 0;  ls_cnt = 0;  fs_first = -1;  fs_last = -1;
    for (int i = 0; i < ncyc; i++) begin
      pe = toggle ? logic'(i % 2 == 0) : 1'b1;
      step(pe, 1'b0);
      if (pe) n++;
      check_out($sformatf("%s_c%0d", name, i), model_out(n, pe));
`ifdef T03_VGA_FRAME_CNT_EN
      check_val($sformatf("%s_vblank_c%0d", name, i), int'(vga_bus.vblank),
                int'(!(((n / 8) % 6 >= 2) && ((n / 8) % 6 <= 4))));
`endif
      if (vga_bus.line_start === 1'b1) ls_cnt++;
      if (vga_bus.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        fs_last = i;
      end
    end
  endtask

  initial begin
    int fs_cnt, ls_cnt, fs_first, fs_last;

    // state after each edge, starting from reset (h=0,v=0)
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));  // h1 v0
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));  // h2
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));  // hold
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));  // h3, v still in sync
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));  // h4
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));  // h5
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));  // h6
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));  // h7
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0));  // h0 v1 line wrap
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));  // hold, pulse drops
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));  // h1
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));  // h2
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));  // h3 (v back porch)
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));  // h4
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));  // h5
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));  // h6
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));  // h7
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0));  // h0 v2
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));  // h1
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));  // h2
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0));  // h3 first visible pixel
    vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 0));  // h4
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0));  // hold in active
    vecs.push_back(mk(1, 0, 1, 1, 1, 2, 0, 0, 0));  // h5
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1));  // restart with pix_en=0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));  // hold at (0,0)
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1));  // restart with pix_en=1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));  // h1

    nRst            = 1'b0;
    vga_bus.pix_en  = 1'b0;
    vga_bus.restart = 1'b0;
    #12;
    check_out("reset_state", model_out(0, 1'b0));
`ifdef T03_VGA_FRAME_CNT_EN
    check_val("reset_frame_cnt", int'(vga_bus.frame_cnt), 0);
    check_val("reset_vblank", int'(vga_bus.vblank), 1);
`endif
    #10;
    nRst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].pe, vecs[i].rs);
      check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // continuous pix_en: two frames
    do_restart();
    run_model(96, 1'b0, "cont", fs_cnt, ls_cnt, fs_first, fs_last);
    check_val("cont_line_starts", ls_cnt, 12);
    check_val("cont_frame_starts", fs_cnt, 2);
    check_val("cont_frame_period", fs_last - fs_first, 48);

    // pix_en toggling: frame stretches to 96 clks
    run_model(192, 1'b1, "tog", fs_cnt, ls_cnt, fs_first, fs_last);
    check_val("tog_frame_starts", fs_cnt, 2);
    check_val("tog_frame_period", fs_last - fs_first, 96);

    // restart from h5,v3
    do_restart();
    run_model(29, 1'b0, "pre_rs", fs_cnt, ls_cnt, fs_first, fs_last);
    step(1'b0, 1'b1);
    n = 0;
    check_out("restart_mid", mk(0, 0, 0, 0, 0, 0, 0, 1, 1).exp);
    step(1'b1, 1'b0);
    n = 1;
    check_out("restart_mid_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0).exp);

    // restart on the natural frame wrap edge
    do_restart();
    run_model(47, 1'b0, "pre_wrap", fs_cnt, ls_cnt, fs_first, fs_last);
    step(1'b1, 1'b1);
    n = 0;
    check_out("restart_at_wrap", model_out(0, 1'b1));
    step(1'b1, 1'b0);
    n = 1;
    check_out("restart_at_wrap_after", model_out(1, 1'b1));
    run_model(4, 1'b0, "post_wrap", fs_cnt, ls_cnt, fs_first, fs_last);

    // async reset in the middle of the active window (px_x=2, px_y=1)
    do_restart();
    run_model(29, 1'b0, "pre_rst", fs_cnt, ls_cnt, fs_first, fs_last);
    check_out("pre_rst_active", mk(0, 0, 1, 1, 1, 2, 1, 0, 0).exp);
    #3;
    nRst = 1'b0;
    #1;
    check_out("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0).exp);
`ifdef T03_VGA_FRAME_CNT_EN
    check_val("async_reset_vblank", int'(vga_bus.vblank), 1);
`endif
    #12;
    nRst = 1'b1;
    n = 0;
    step(1'b0, 1'b0);
    check_out("post_reset_hold", model_out(0, 1'b0));
`ifdef T03_VGA_FRAME_CNT_EN
    check_val("post_reset_frame_cnt", int'(vga_bus.frame_cnt), 0);
`endif

    // three full frames
    run_model(144, 1'b0, "frames3", fs_cnt, ls_cnt, fs_first, fs_last);
    check_val("frames3_frame_starts", fs_cnt, 3);
`ifdef T03_VGA_FRAME_CNT_EN
    check_val("frames3_frame_cnt", int'(vga_bus.frame_cnt), 3);
    do_restart();
    check_val("frame_cnt_restart", int'(vga_bus.frame_cnt), 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
